// File: rtl/fc_layer_engine_if.sv
// Bus bundle between the FC layer engine and its two single-port BRAMs.
// The master side is the engine; the slave side is the BRAM pair.
interface fc_layer_engine_if #(
    parameter int DATA_SIZE = 16
);
    logic                 bias_weights_bram_ena;
    logic [15:0]          bias_weights_bram_addra;
    logic [DATA_SIZE-1:0] bias_weights_bram_douta;
    logic                 result_bram_ena;
    logic                 result_bram_wea;
    logic [12:0]          result_bram_addra;
    logic [DATA_SIZE-1:0] result_bram_dina;
    logic [DATA_SIZE-1:0] result_bram_douta;

    modport master (
        output bias_weights_bram_ena, bias_weights_bram_addra,
        output result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina,
        input  bias_weights_bram_douta, result_bram_douta
    );

    modport slave (
        input  bias_weights_bram_ena, bias_weights_bram_addra,
        input  result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina,
        output bias_weights_bram_douta, result_bram_douta
    );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: y[o] = sat(bias[o] + sum_i w[o][i]*x[i]) with optional ReLU,
// streamed one weight/input pair per cycle from BRAM, with argmax tracking for classification.
module fc_layer_engine #(
    parameter int IN_SIZE   = 84,
    parameter int OUT_SIZE  = 10,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int RD_LAT    = 2,
    parameter int W_BASE    = 61276,
    parameter int W_STRIDE  = 100,
    parameter int B_BASE    = 62276,
    parameter int IN_BASE   = 8000,
    parameter int OUT_BASE  = 8084,
    parameter int RELU      = 0,
    localparam int ARG_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fc_en,
    fc_layer_engine_if.master             bram,
    output logic                          fc_finish,
    output logic [DATA_SIZE*OUT_SIZE-1:0] out_result,
    output logic [ARG_W-1:0]              out_argmax
);
    localparam int ACC_W = 2*DATA_SIZE + $clog2(IN_SIZE+1);
    localparam logic signed [DATA_SIZE-1:0] Y_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] Y_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_STREAM, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                        state;
    logic                          armed;
    logic [15:0]                   row;
    logic [15:0]                   cnt;
    logic                          abort;
    logic [RD_LAT-1:0]             bias_pipe;
    logic [RD_LAT-1:0]             w_pipe;
    logic signed [2*DATA_SIZE-1:0] prod;
    logic                          prod_valid;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       acc_next;
    logic signed [ACC_W-1:0]       shifted;
    logic [ACC_W-DATA_SIZE:0]      upper;
    logic signed [ACC_W-1:0]       bias_ext;
    logic signed [DATA_SIZE-1:0]   w_s;
    logic signed [DATA_SIZE-1:0]   x_s;
    logic signed [DATA_SIZE-1:0]   y;
    logic signed [DATA_SIZE-1:0]   max_val;
    logic [ARG_W-1:0]              max_idx;

    assign w_s      = bram.bias_weights_bram_douta;
    assign x_s      = bram.result_bram_douta;
    assign bias_ext = {{(ACC_W-DATA_SIZE){w_s[DATA_SIZE-1]}}, w_s};
    assign abort    = !fc_en && (state inside {S_BIAS, S_STREAM, S_DRAIN, S_WRITE});

    // NOTE: every variable gets a default first so always_comb can never infer a latch.
    always_comb begin
        acc_next = acc;
        if (prod_valid)
            acc_next = acc + {{(ACC_W-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
        shifted = acc_next >>> FRAC_BITS;
        upper   = shifted[ACC_W-1:DATA_SIZE-1];
        if (upper == '0 || upper == '1)
            y = shifted[DATA_SIZE-1:0];
        else if (shifted[ACC_W-1])
            y = Y_MIN;
        else
            y = Y_MAX;
        if (RELU != 0 && y[DATA_SIZE-1])
            y = '0;
    end

    // Read-return tracking: a bit enters the pipe on the issue cycle and exits when douta is valid.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            bias_pipe  <= '0;
            w_pipe     <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            bias_pipe  <= (bias_pipe << 1) | RD_LAT'(state == S_BIAS);
            w_pipe     <= (w_pipe << 1) | RD_LAT'(state == S_STREAM);
            prod_valid <= w_pipe[RD_LAT-1];
            if (w_pipe[RD_LAT-1])
                prod <= w_s * x_s;
            if (bias_pipe[RD_LAT-1])
                acc <= bias_ext <<< FRAC_BITS;
            else
                acc <= acc_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                        <= S_IDLE;
            armed                        <= 1'b1;
            row                          <= '0;
            cnt                          <= '0;
            bram.bias_weights_bram_ena   <= 1'b0;
            bram.bias_weights_bram_addra <= '0;
            bram.result_bram_ena         <= 1'b0;
            bram.result_bram_wea         <= 1'b0;
            bram.result_bram_addra       <= '0;
            bram.result_bram_dina        <= '0;
            fc_finish                    <= 1'b0;
            out_result                   <= '0;
            out_argmax                   <= '0;
            max_val                      <= Y_MIN;
            max_idx                      <= '0;
        end else begin
            bram.bias_weights_bram_ena <= 1'b0;
            bram.result_bram_ena       <= 1'b0;
            bram.result_bram_wea       <= 1'b0;
            fc_finish                  <= 1'b0;

            // A completed run must see fc_en low before it can start again.
            if (state == S_DONE)
                armed <= 1'b0;
            else if (!fc_en)
                armed <= 1'b1;

            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (fc_en && armed) begin
                        state                        <= S_BIAS;
                        row                          <= '0;
                        max_val                      <= Y_MIN;
                        max_idx                      <= '0;
                        bram.bias_weights_bram_ena   <= 1'b1;
                        bram.bias_weights_bram_addra <= 16'(B_BASE);
                    end
                    S_BIAS: begin
                        state                        <= S_STREAM;
                        cnt                          <= '0;
                        bram.bias_weights_bram_ena   <= 1'b1;
                        bram.bias_weights_bram_addra <= 16'(W_BASE + int'(row)*W_STRIDE);
                        bram.result_bram_ena         <= 1'b1;
                        bram.result_bram_addra       <= 13'(IN_BASE);
                    end
                    S_STREAM: if (cnt == 16'(IN_SIZE-1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt                          <= cnt + 16'd1;
                        bram.bias_weights_bram_ena   <= 1'b1;
                        bram.bias_weights_bram_addra <= 16'(W_BASE + int'(row)*W_STRIDE + int'(cnt) + 1);
                        bram.result_bram_ena         <= 1'b1;
                        bram.result_bram_addra       <= 13'(IN_BASE + int'(cnt) + 1);
                    end
                    S_DRAIN: if (cnt == 16'(RD_LAT)) begin
                        // y already includes the final product landing on this edge.
                        state                                          <= S_WRITE;
                        bram.result_bram_ena                           <= 1'b1;
                        bram.result_bram_wea                           <= 1'b1;
                        bram.result_bram_addra                         <= 13'(OUT_BASE + int'(row));
                        bram.result_bram_dina                          <= y;
                        out_result[int'(row)*DATA_SIZE +: DATA_SIZE]   <= y;
                        if (y > max_val) begin
                            max_val <= y;
                            max_idx <= ARG_W'(row);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                    S_WRITE: if (row == 16'(OUT_SIZE-1)) begin
                        state      <= S_DONE;
                        fc_finish  <= 1'b1;
                        out_argmax <= max_idx;
                    end else begin
                        state                        <= S_BIAS;
                        row                          <= row + 16'd1;
                        bram.bias_weights_bram_ena   <= 1'b1;
                        bram.bias_weights_bram_addra <= 16'(B_BASE + int'(row) + 1);
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
